// File: rtl/snax_hwpe_arb_pkg.sv
// Shared types for the HWPE peripheral-port arbiter.
//   periph_req_t  : one register-port request (address, read/write, byte enables, write data)
//   arb_state_e   : arbiter FSM states
//   PeriphIdWidth : width of the transaction id carried on the shared port
package snax_hwpe_arb_pkg;

  localparam int PeriphIdWidth = 5;

  typedef struct packed {
    logic [31:0] add;
    logic        wen;   // 1 = read, 0 = write
    logic [3:0]  be;
    logic [31:0] data;
  } periph_req_t;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } arb_state_e;

endpackage

// File: rtl/hwpe_ctrl_intf_periph.sv
// HWPE register (peripheral) port bundle.
//   master drives req/add/wen/be/data/id and receives gnt/r_valid/r_data/r_id.
interface hwpe_ctrl_intf_periph #(
  parameter int ID_WIDTH = 5
);
  logic                req;
  logic                gnt;
  logic [31:0]         add;
  logic                wen;
  logic [3:0]          be;
  logic [31:0]         data;
  logic [ID_WIDTH-1:0] id;
  logic                r_valid;
  logic [31:0]         r_data;
  logic [ID_WIDTH-1:0] r_id;

  modport master (
    output req, add, wen, be, data, id,
    input  gnt, r_valid, r_data, r_id
  );

  modport slave (
    input  req, add, wen, be, data, id,
    output gnt, r_valid, r_data, r_id
  );
endinterface

// File: rtl/fifo_v3.sv
// Small synchronous FIFO used as a per-requester response buffer.
//   clk_i/rst_i : clock, synchronous active-high reset (empties the FIFO)
//   push_i/data_i/full_o  : write side; pushes while full are ignored
//   pop_i/data_o/empty_o  : read side; data_o shows the head entry
module fifo_v3 #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  full_o,
  output logic                  empty_o,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] data_o
);
  localparam int PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CntW = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]       rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]       cnt_q;
  logic                  do_push, do_pop;

  assign full_o  = (cnt_q == CntW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign data_o  = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage holds data only, so it is left out of reset.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/snax_hwpe_periph_arbiter.sv
// Shares one HWPE register port between NumReq requesters.
//   req_valid_i/req_ready_o/req_i : per-requester request handshake and payload
//   rsp_valid_o/rsp_ready_i/rsp_data_o : per-requester response streams
//   periph : shared register port (master side)
//   err_o  : sticky flag for responses with an unknown id or no buffer room
// A requester may only issue while it holds a credit; credits equal the free
// slots of its response buffer, so a stalled consumer throttles only itself.
module snax_hwpe_periph_arbiter
  import snax_hwpe_arb_pkg::*;
#(
  parameter int NumReq   = 2,
  parameter int RspDepth = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic        [NumReq-1:0]     req_valid_i,
  output logic        [NumReq-1:0]     req_ready_o,
  input  periph_req_t [NumReq-1:0]     req_i,
  output logic        [NumReq-1:0]     rsp_valid_o,
  input  logic        [NumReq-1:0]     rsp_ready_i,
  output logic        [NumReq-1:0][31:0] rsp_data_o,
  hwpe_ctrl_intf_periph.master         periph,
  output logic                         err_o
);
  localparam int IdxW = $clog2(NumReq);
  localparam int CrdW = $clog2(RspDepth + 1);

  arb_state_e             state_q, state_d;
  logic [IdxW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [CrdW-1:0]        credit_q [NumReq];
  logic                   err_q, err_d;
  periph_req_t            pl_q;
  logic [PeriphIdWidth-1:0] id_q;

  logic [NumReq-1:0]      eligible, dec, push, pop, full, empty;
  logic [IdxW-1:0]        winner, idx;
  logic                   found, accept, rsp_err;
  int                     j;

  // Round-robin search starting at rr_ptr_q.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NumReq; i++) begin
      eligible[i] = req_valid_i[i] && (credit_q[i] != '0);
    end
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    j      = 0;
    for (int k = 0; k < NumReq; k++) begin
      j = int'(rr_ptr_q) + k;
      if (j >= NumReq) j = j - NumReq;
      idx = IdxW'(j);
      if (!found && eligible[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  assign accept = (state_q == IDLE) && found && !rst_i;

  always_comb begin
    req_ready_o = '0;
    if (accept) req_ready_o[winner] = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = ISSUE;
          rr_ptr_d = (winner == IdxW'(NumReq - 1)) ? '0 : winner + 1'b1;
        end
      end
      ISSUE: begin
        if (periph.gnt) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      pl_q     <= '0;
      id_q     <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      err_q    <= err_d;
      if (accept) begin
        pl_q <= req_i[winner];
        id_q <= PeriphIdWidth'(winner);
      end
    end
  end

  // Outputs are forced idle combinationally so reset takes effect in its first cycle.
  assign periph.req  = (state_q == ISSUE) && !rst_i;
  assign periph.add  = rst_i ? '0 : pl_q.add;
  assign periph.wen  = rst_i ? 1'b0 : pl_q.wen;
  assign periph.be   = rst_i ? '0 : pl_q.be;
  assign periph.data = rst_i ? '0 : pl_q.data;
  assign periph.id   = rst_i ? '0 : id_q;
  assign err_o       = err_q && !rst_i;

  // Response steering: route by r_id, drop and flag anything unroutable.
  always_comb begin
    push    = '0;
    rsp_err = 1'b0;
    if (periph.r_valid && !rst_i) begin
      if (int'(periph.r_id) >= NumReq) begin
        rsp_err = 1'b1;
      end else begin
        for (int i = 0; i < NumReq; i++) begin
          if (periph.r_id == PeriphIdWidth'(i)) begin
            if (full[i]) rsp_err = 1'b1;
            else         push[i] = 1'b1;
          end
        end
      end
    end
    err_d = err_q | rsp_err;
  end

  assign rsp_valid_o = ~empty & {NumReq{~rst_i}};
  assign pop         = rsp_valid_o & rsp_ready_i;

  for (genvar g = 0; g < NumReq; g++) begin : gen_rsp_buf
    fifo_v3 #(
      .DATA_WIDTH(32),
      .DEPTH     (RspDepth)
    ) i_rsp_fifo (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .push_i (push[g]),
      .data_i (periph.r_data),
      .full_o (full[g]),
      .empty_o(empty[g]),
      .pop_i  (pop[g]),
      .data_o (rsp_data_o[g])
    );
  end

  always_comb begin
    for (int i = 0; i < NumReq; i++) begin
      dec[i] = accept && (winner == IdxW'(i));
    end
  end

  // A pop without an accept is clamped at RspDepth: a response to an aborted
  // transaction may still be buffered and drained after reset.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NumReq; i++) begin
      if (rst_i) begin
        credit_q[i] <= CrdW'(RspDepth);
      end else if (dec[i] && !pop[i]) begin
        credit_q[i] <= credit_q[i] - 1'b1;
      end else if (pop[i] && !dec[i] && (credit_q[i] != CrdW'(RspDepth))) begin
        credit_q[i] <= credit_q[i] + 1'b1;
      end
    end
  end

endmodule
